control_unit: RTL and testbench

- Control unit of the single-issue, single-cycle MIRI datapath.
- Decodes the 32-bit instruction from the instruction cache into datapath mux selects, register-file write enable, data-cache request and cache-refill enables.
- Runs a small miss-handling FSM that freezes the PC and architectural writes while an instruction- or data-cache line is refilled from memory.
- Sits between iCache/dCache and regFile/alu/mux selects.

---
 rtl/uc_pkg.sv | 65 ++++++
 rtl/uc_decoder.sv | 51 +++++
 rtl/control_unit.sv | 135 +++++++++++++
 tb/tb_control_unit.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/uc_pkg.sv
// uc_pkg: shared definitions for the MIRI control unit.
// Holds the opcode values, the datapath select encodings, the miss-handling
// state enum and the packed control word that the decoder produces.
package uc_pkg;

    // Opcode values in instr[31:25]
    localparam logic [6:0] OPC_ADD = 7'h00;
    localparam logic [6:0] OPC_SUB = 7'h01;
    localparam logic [6:0] OPC_MUL = 7'h02;
    localparam logic [6:0] OPC_LDW = 7'h11;
    localparam logic [6:0] OPC_STW = 7'h13;
    localparam logic [6:0] OPC_BEQ = 7'h30;
    localparam logic [6:0] OPC_JMP = 7'h31;

    // ALU y operand select
    typedef enum logic [1:0] {
        MUXB_RB    = 2'b00,
        MUXB_IMM   = 2'b01,
        MUXB_RDIMM = 2'b10,
        MUXB_ZERO  = 2'b11
    } mux_b_e;

    // Next-pc select
    typedef enum logic [1:0] {
        PC_SEQ    = 2'b00,
        PC_BRANCH = 2'b01,
        PC_ALU    = 2'b10,
        PC_VECTOR = 2'b11
    } mux_pc_e;

    // dCache request
    typedef enum logic [1:0] {
        DC_NONE  = 2'b00,
        DC_LOAD  = 2'b01,
        DC_STORE = 2'b10,
        DC_RSVD  = 2'b11
    } dc_req_e;

    // Miss-handling FSM states
    typedef enum logic [1:0] {
        RUN     = 2'b00,
        IC_WAIT = 2'b01,
        DC_WAIT = 2'b10
    } state_e;

    // Decoded control word for one instruction
    typedef struct packed {
        mux_b_e  mux_b;
        logic    mux_addr_b;
        logic    mux_d;
        mux_pc_e mux_pc;
        logic    rf_wrd;
        dc_req_e dc_rd_wr;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '{
        mux_b:      MUXB_RB,
        mux_addr_b: 1'b0,
        mux_d:      1'b0,
        mux_pc:     PC_SEQ,
        rf_wrd:     1'b0,
        dc_rd_wr:   DC_NONE
    };

endpackage

// File: rtl/uc_decoder.sv
// uc_decoder: pure combinational opcode to control-word decode.
// Optional build macro ILLEGAL_TRAP_EN: unknown opcodes redirect the pc to
// vector 0 instead of behaving as a NOP.
module uc_decoder
    import uc_pkg::*;
#(
    parameter int unsigned OPC_WIDTH = 7
) (
    input  logic [OPC_WIDTH-1:0] opc_i,
    output ctrl_t                ctrl_o
);

    // Map each opcode to its datapath selects and enables
    always_comb begin
        // NOTE: every field gets a default first so no path leaves it unassigned, which would infer a latch.
        ctrl_o = CTRL_NOP;
        unique case (opc_i)
            OPC_WIDTH'(OPC_ADD),
            OPC_WIDTH'(OPC_SUB),
            OPC_WIDTH'(OPC_MUL): begin
                ctrl_o.rf_wrd = 1'b1;
            end
            OPC_WIDTH'(OPC_LDW): begin
                ctrl_o.mux_b    = MUXB_IMM;
                ctrl_o.mux_d    = 1'b1;
                ctrl_o.rf_wrd   = 1'b1;
                ctrl_o.dc_rd_wr = DC_LOAD;
            end
            OPC_WIDTH'(OPC_STW): begin
                ctrl_o.mux_addr_b = 1'b1;
                ctrl_o.mux_b      = MUXB_RDIMM;
                ctrl_o.dc_rd_wr   = DC_STORE;
            end
            OPC_WIDTH'(OPC_BEQ): begin
                ctrl_o.mux_pc = PC_BRANCH;
            end
            OPC_WIDTH'(OPC_JMP): begin
                ctrl_o.mux_b  = MUXB_IMM;
                ctrl_o.mux_pc = PC_ALU;
            end
            default: begin
`ifdef ILLEGAL_TRAP_EN
                ctrl_o.mux_pc = PC_VECTOR;
`else
                ctrl_o.mux_pc = PC_SEQ;
`endif
            end
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// control_unit: MIRI single-cycle control unit.
// Decodes the instruction, and on an iCache/dCache miss freezes the pc and
// architectural writes for MEM_LATENCY cycles before pulsing the refill write.
// Optional build macro ILLEGAL_TRAP_EN (handled in uc_decoder).
module control_unit
    import uc_pkg::*;
#(
    parameter int unsigned MEM_LATENCY = 4,
    parameter int unsigned OPC_WIDTH   = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        iCacheMiss,
    input  logic        dCacheMiss,
    output logic [1:0]  MuxB,
    output logic        MuxAddrB,
    output logic        MuxD,
    output logic [1:0]  MuxPc,
    output logic        PC_we,
    output logic        RF_wrd,
    output logic [1:0]  DC_rd_wr,
    output logic        DC_we,
    output logic        IC_we
);

    localparam logic [3:0] CNT_LAST = 4'(MEM_LATENCY - 1);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    ctrl_t      dec;
    ctrl_t      ctrl;
    logic       pc_we;
    logic       ic_we;
    logic       dc_we;

    // Only the opcode field matters here; the rest feeds the datapath
    logic unused_fields;
    assign unused_fields = ^instr[31-OPC_WIDTH:0];

    uc_decoder #(
        .OPC_WIDTH(OPC_WIDTH)
    ) u_decoder (
        .opc_i (instr[31 -: OPC_WIDTH]),
        .ctrl_o(dec)
    );

    // State and wait counter; reset aborts any refill in progress
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state, counter and gating of the decoded control word
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ctrl    = dec;
        pc_we   = 1'b0;
        ic_we   = 1'b0;
        dc_we   = 1'b0;
        unique case (state_q)
            RUN: begin
                pc_we = 1'b1;
                cnt_d = '0;
                if (iCacheMiss) begin
                    state_d       = IC_WAIT;
                    pc_we         = 1'b0;
                    ctrl.rf_wrd   = 1'b0;
                    ctrl.dc_rd_wr = DC_NONE;
                end else if (dCacheMiss && (dec.dc_rd_wr != DC_NONE)) begin
                    state_d       = DC_WAIT;
                    pc_we         = 1'b0;
                    ctrl.rf_wrd   = 1'b0;
                    ctrl.dc_rd_wr = DC_NONE;
                end
            end
            IC_WAIT: begin
                ctrl.rf_wrd   = 1'b0;
                ctrl.dc_rd_wr = DC_NONE;
                cnt_d         = cnt_q + 4'd1;
                if (cnt_q == CNT_LAST) begin
                    ic_we   = 1'b1;
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            DC_WAIT: begin
                // The request stays visible to the dCache during the refill
                ctrl.rf_wrd = 1'b0;
                cnt_d       = cnt_q + 4'd1;
                if (cnt_q == CNT_LAST) begin
                    dc_we   = 1'b1;
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
    end

    // While reset is held every output is forced low
    always_comb begin
        MuxB     = 2'b00;
        MuxAddrB = 1'b0;
        MuxD     = 1'b0;
        MuxPc    = 2'b00;
        PC_we    = 1'b0;
        RF_wrd   = 1'b0;
        DC_rd_wr = 2'b00;
        DC_we    = 1'b0;
        IC_we    = 1'b0;
        if (rst_n) begin
            MuxB     = ctrl.mux_b;
            MuxAddrB = ctrl.mux_addr_b;
            MuxD     = ctrl.mux_d;
            MuxPc    = ctrl.mux_pc;
            PC_we    = pc_we;
            RF_wrd   = ctrl.rf_wrd;
            DC_rd_wr = ctrl.dc_rd_wr;
            DC_we    = dc_we;
            IC_we    = ic_we;
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed plus randomized bench for control_unit.
// Expected outputs come from an opcode table and a countdown miss model.
module tb_control_unit;

    localparam int MEM_LAT = 4;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr;
    logic        iCacheMiss;
    logic        dCacheMiss;
    logic [1:0]  MuxB;
    logic        MuxAddrB;
    logic        MuxD;
    logic [1:0]  MuxPc;
    logic        PC_we;
    logic        RF_wrd;
    logic [1:0]  DC_rd_wr;
    logic        DC_we;
    logic        IC_we;

    control_unit #(
        .MEM_LATENCY(MEM_LAT),
        .OPC_WIDTH  (7)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .instr     (instr),
        .iCacheMiss(iCacheMiss),
        .dCacheMiss(dCacheMiss),
        .MuxB      (MuxB),
        .MuxAddrB  (MuxAddrB),
        .MuxD      (MuxD),
        .MuxPc     (MuxPc),
        .PC_we     (PC_we),
        .RF_wrd    (RF_wrd),
        .DC_rd_wr  (DC_rd_wr),
        .DC_we     (DC_we),
        .IC_we     (IC_we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output bundle: MuxB, MuxAddrB, MuxD, MuxPc, PC_we, RF_wrd, DC_rd_wr, DC_we, IC_we
    typedef struct packed {
        logic [1:0] mux_b;
        logic       mab;
        logic       mux_d;
        logic [1:0] mux_pc;
        logic       pc_we;
        logic       rf_wrd;
        logic [1:0] dc;
        logic       dc_we;
        logic       ic_we;
    } outs_t;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: 0 = executing, 1 = iCache refill, 2 = dCache refill
    int m_mode = 0;
    int m_left = 0;
    bit m_hit  = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Opcode table straight from the instruction set description
    function automatic outs_t ref_decode(input logic [31:0] ins);
        outs_t e;
        e = '0;
        case (ins[31:25])
            7'h00, 7'h01, 7'h02: e.rf_wrd = 1'b1;
            7'h11: begin e.mux_b = 2'b01; e.mux_d = 1'b1; e.rf_wrd = 1'b1; e.dc = 2'b01; end
            7'h13: begin e.mab = 1'b1; e.mux_b = 2'b10; e.dc = 2'b10; end
            7'h30: e.mux_pc = 2'b01;
            7'h31: begin e.mux_b = 2'b01; e.mux_pc = 2'b10; end
            default: begin
`ifdef ILLEGAL_TRAP_EN
                e.mux_pc = 2'b11;
`else
                e.mux_pc = 2'b00;
`endif
            end
        endcase
        return e;
    endfunction

    function automatic outs_t observed();
        return {MuxB, MuxAddrB, MuxD, MuxPc, PC_we, RF_wrd, DC_rd_wr, DC_we, IC_we};
    endfunction

    // One clock: drive inputs, check at the falling edge, advance model at the rising edge
    task automatic cycle(input string tag, input logic [31:0] ins, input logic im, input logic dm);
        outs_t e;
        int    nmode, nleft;
        instr      = ins;
        iCacheMiss = im;
        dCacheMiss = dm;
        @(negedge clk);
        e     = ref_decode(ins);
        nmode = m_mode;
        nleft = m_left;
        m_hit = 1'b0;
        if (!rst_n) begin
            e     = '0;
            nmode = 0;
        end else if (m_mode == 0) begin
            e.pc_we = 1'b1;
            if (im || (dm && e.dc != 2'b00)) begin
                e.pc_we  = 1'b0;
                e.rf_wrd = 1'b0;
                e.dc     = 2'b00;
                nmode    = im ? 1 : 2;
                nleft    = MEM_LAT;
            end else begin
                m_hit = 1'b1;
            end
        end else begin
            e.rf_wrd = 1'b0;
            if (m_mode == 1) e.dc = 2'b00;
            nleft = m_left - 1;
            if (nleft == 0) begin
                if (m_mode == 1) e.ic_we = 1'b1;
                else             e.dc_we = 1'b1;
                nmode = 0;
            end
        end
        check(tag, 32'(observed()), 32'(e));
        @(posedge clk);
        m_mode = nmode;
        m_left = nleft;
        #1;
    endtask

    localparam logic [31:0] I_ADD = 32'h0030_8800;
    localparam logic [31:0] I_LDW = 32'h2240_8008;
    localparam logic [31:0] I_STW = 32'h2640_8008;
    localparam logic [31:0] I_BEQ = 32'h6000_0000;
    localparam logic [31:0] I_JMP = 32'h6200_0010;
    localparam logic [31:0] I_BAD = 32'h7E00_0000;

    function automatic logic [31:0] rand_instr();
        logic [6:0] opcs [7];
        logic [6:0] opc;
        int         k;
        opcs = '{7'h00, 7'h01, 7'h02, 7'h11, 7'h13, 7'h30, 7'h31};
        k = int'($urandom_range(0, 8));
        opc = (k < 7) ? opcs[k] : 7'($urandom);
        return {opc, 25'($urandom)};
    endfunction

    initial begin
        logic [31:0] cur;
        bit          replay;
        rst_n      = 1'b0;
        instr      = '0;
        iCacheMiss = 1'b0;
        dCacheMiss = 1'b0;

        // Reset state
        cycle("reset0", I_ADD, 1'b0, 1'b0);
        cycle("reset1", I_LDW, 1'b1, 1'b1);
        rst_n = 1'b1;

        // Decode of each instruction class
        cycle("add", I_ADD, 1'b0, 1'b0);
        cycle("stw", I_STW, 1'b0, 1'b0);
        cycle("beq", I_BEQ, 1'b0, 1'b0);
        cycle("jmp", I_JMP, 1'b0, 1'b0);
        cycle("unknown", I_BAD, 1'b0, 1'b0);
        cycle("add_dmiss_ignored", I_ADD, 1'b0, 1'b1);

        // Load miss: miss cycle, four wait cycles, then the replay hits
        cycle("ldw_miss", I_LDW, 1'b0, 1'b1);
        for (int i = 0; i < MEM_LAT; i++) cycle("ldw_wait", I_LDW, 1'b0, 1'b1);
        cycle("ldw_hit", I_LDW, 1'b0, 1'b0);

        // Store miss
        cycle("stw_miss", I_STW, 1'b0, 1'b1);
        for (int i = 0; i < MEM_LAT; i++) cycle("stw_wait", I_STW, 1'b0, 1'b0);
        cycle("stw_hit", I_STW, 1'b0, 1'b0);

        // iCache miss wins over dCache miss
        cycle("both_miss", I_LDW, 1'b1, 1'b1);
        for (int i = 0; i < MEM_LAT; i++) cycle("ic_wait", I_LDW, 1'b1, 1'b1);
        cycle("after_ic", I_LDW, 1'b0, 1'b0);

        // Reset in the middle of an iCache refill (counter at 2)
        cycle("ic_miss2", I_ADD, 1'b1, 1'b0);
        cycle("ic_w0", I_ADD, 1'b0, 1'b0);
        cycle("ic_w1", I_ADD, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("rst_async", 32'(observed()), 32'h0);
        m_mode = 0;
        m_left = 0;
        cycle("rst_hold", I_ADD, 1'b0, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < MEM_LAT + 2; i++) cycle("post_rst", I_ADD, 1'b0, 1'b0);

        // Randomized traffic; the instruction is held until it completes without a miss
        cur    = rand_instr();
        replay = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (m_mode == 0 && !replay) cur = rand_instr();
            cycle("random", cur, ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0));
            if (m_hit) replay = 1'b0;
            else if (m_mode != 0) replay = 1'b1;
            if ($urandom_range(0, 199) == 0) begin
                rst_n = 1'b0;
                #1;
                check("rand_rst", 32'(observed()), 32'h0);
                m_mode = 0;
                m_left = 0;
                replay = 1'b0;
                cycle("rand_rst_hold", cur, 1'b0, 1'b0);
                rst_n = 1'b1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
